// File: rtl/axi_pwm_custom_fade_ctrl.sv
// ---------------------------------------------------------------------------
// axi_pwm_custom_fade_ctrl
//
// Purpose:
//   Drives the four duty inputs of the custom PWM LED interface. Each channel
//   is moved toward a software target using one of three behaviours:
//   - jump directly to the target
//   - ramp linearly to the target
//   - breathe as a triangle wave between 0 and the target, until stopped
//   Duty updates are paced by an internal PWM-period tick and a programmable
//   divider, so a channel's duty changes at most once per PWM period.
//
// Parameters:
//   PWM_PERIOD : clock cycles per PWM period (sets the internal tick rate)
//   DW         : duty width, must match the PWM interface
//
// Ports:
//   pwm_clk            in   clock for all logic
//   rst                in   asynchronous active-high reset
//   start              in   one-cycle pulse, begins a sequence from IDLE
//   stop               in   one-cycle pulse, aborts RUN and holds duties
//   mode[1:0]          in   0 direct, 1 ramp, 2 breathe, 3 treated as direct
//   step[DW-1:0]       in   duty increment per update (0 behaves as 1)
//   div[7:0]           in   update every div+1 PWM periods
//   target_0..3        in   per-channel target duty
//   data_channel_0..3  out  registered duty to the PWM interface
//   busy               out  high while a sequence is running
//   done               out  one-cycle pulse when direct/ramp completes
// ---------------------------------------------------------------------------
module axi_pwm_custom_fade_ctrl #(
  parameter int PWM_PERIOD = 4095,
  parameter int DW         = 12
) (
  input  logic          pwm_clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] step,
  input  logic [7:0]    div,
  input  logic [DW-1:0] target_0,
  input  logic [DW-1:0] target_1,
  input  logic [DW-1:0] target_2,
  input  logic [DW-1:0] target_3,
  output logic [DW-1:0] data_channel_0,
  output logic [DW-1:0] data_channel_1,
  output logic [DW-1:0] data_channel_2,
  output logic [DW-1:0] data_channel_3,
  output logic          busy,
  output logic          done
);

  localparam int            PW       = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PWM_PERIOD - 1);

  localparam logic [1:0] MODE_RAMP    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Period tick and update pacing
  logic [PW-1:0] per_cnt;
  logic          tick;
  logic [7:0]    div_cnt;
  logic          upd;

  // Shadow copies of the request, frozen for the whole sequence
  logic [1:0]    mode_s;
  logic [DW-1:0] step_s;
  logic [7:0]    div_s;
  logic [DW-1:0] tgt_s [4];
  logic [DW-1:0] tgt_in [4];

  // Channel state
  logic [DW-1:0] cur [4];
  logic [3:0]    dir_down;
  logic          loaded;

  // Per-channel next-value arithmetic, one bit wider than the duty
  logic [DW:0]   up_sum   [4];
  logic [DW:0]   dn_diff  [4];
  logic [DW-1:0] ramp_nxt [4];
  logic [DW-1:0] brth_nxt [4];
  logic [3:0]    brth_flip;
  logic [3:0]    at_tgt;
  logic          all_at_tgt;

  // FSM control strobes
  logic capture;
  logic load_direct;
  logic apply_upd;
  logic done_nxt;

  assign tgt_in[0] = target_0;
  assign tgt_in[1] = target_1;
  assign tgt_in[2] = target_2;
  assign tgt_in[3] = target_3;

  assign data_channel_0 = cur[0];
  assign data_channel_1 = cur[1];
  assign data_channel_2 = cur[2];
  assign data_channel_3 = cur[3];

  assign busy = (state == RUN);

  assign tick = (per_cnt == PER_LAST);
  assign upd  = (state == RUN) && tick && (div_cnt == div_s);

  // Free-running PWM period counter; it never stops so the tick phase is
  // independent of when sequences start.
  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PW'(1);
    end
  end

  // Divider counter: counts ticks while running and clears whenever an
  // update fires, so updates land every div+1 ticks after RUN entry.
  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (capture) begin
      div_cnt <= '0;
    end else if ((state == RUN) && tick) begin
      if (div_cnt == div_s) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  // Shadow registers load only when a start is accepted, so register-bank
  // writes during a sequence cannot disturb it. A zero step would stall a
  // ramp forever, so it is promoted to one.
  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      mode_s <= '0;
      step_s <= '0;
      div_s  <= '0;
      for (int i = 0; i < 4; i++) begin
        tgt_s[i] <= '0;
      end
    end else if (capture) begin
      mode_s <= mode;
      step_s <= (step == '0) ? DW'(1) : step;
      div_s  <= div;
      for (int i = 0; i < 4; i++) begin
        tgt_s[i] <= tgt_in[i];
      end
    end
  end

  // Next-duty arithmetic. Sums and differences are kept at DW+1 bits: the
  // extra bit catches overflow above full scale and, for differences, acts
  // as a sign bit so a step larger than the current duty clamps rather than
  // wrapping to a large value.
  always_comb begin
    brth_flip = '0;
    at_tgt    = '0;
    for (int i = 0; i < 4; i++) begin
      up_sum[i]   = {1'b0, cur[i]} + {1'b0, step_s};
      dn_diff[i]  = {1'b0, cur[i]} - {1'b0, step_s};
      at_tgt[i]   = (cur[i] == tgt_s[i]);
      ramp_nxt[i] = cur[i];
      if (cur[i] < tgt_s[i]) begin
        ramp_nxt[i] = (up_sum[i] > {1'b0, tgt_s[i]}) ? tgt_s[i] : up_sum[i][DW-1:0];
      end else if (cur[i] > tgt_s[i]) begin
        ramp_nxt[i] = ($signed(dn_diff[i]) < $signed({1'b0, tgt_s[i]})) ?
                      tgt_s[i] : dn_diff[i][DW-1:0];
      end
      if (dir_down[i]) begin
        brth_nxt[i]  = dn_diff[i][DW] ? '0 : dn_diff[i][DW-1:0];
        brth_flip[i] = (brth_nxt[i] == '0);
      end else begin
        brth_nxt[i]  = (up_sum[i] > {1'b0, tgt_s[i]}) ? tgt_s[i] : up_sum[i][DW-1:0];
        brth_flip[i] = (brth_nxt[i] == tgt_s[i]);
      end
    end
  end

  assign all_at_tgt = &at_tgt;

  // FSM state register
  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and control strobes. Stop has priority over everything:
  // it cancels an accept in IDLE and suppresses any update or completion in
  // RUN. Direct mode spends one RUN cycle loading and a second reporting.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    load_direct = 1'b0;
    apply_upd   = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          capture   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (mode_s == MODE_RAMP) begin
          if (all_at_tgt) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            apply_upd = upd;
          end
        end else if (mode_s == MODE_BREATHE) begin
          apply_upd = upd;
        end else begin
          if (!loaded) begin
            load_direct = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel duty registers plus breathe direction and the direct-load flag.
  // Duties move only on a direct load or an accepted update.
  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      dir_down <= '0;
      loaded   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cur[i] <= '0;
      end
    end else if (capture) begin
      dir_down <= '0;
      loaded   <= 1'b0;
    end else if (load_direct) begin
      loaded <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        cur[i] <= tgt_s[i];
      end
    end else if (apply_upd) begin
      for (int i = 0; i < 4; i++) begin
        if (mode_s == MODE_BREATHE) begin
          cur[i] <= brth_nxt[i];
          if (brth_flip[i]) begin
            dir_down[i] <= ~dir_down[i];
          end
        end else begin
          cur[i] <= ramp_nxt[i];
        end
      end
    end
  end

  // Completion pulse, registered so it coincides with busy falling.
  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= done_nxt;
    end
  end

endmodule
